fir_result_fifo: RTL

Downstream stage of the FIR accelerator core. Captures each new MAC result when the core flags it valid, and buffers results in a small FIFO. The CPU drains the FIFO through the register interface without missing samples between polls. Provides occupancy, sticky overflow/underflow flags and a threshold interrupt for the X-HEEP wrapper.

---
 rtl/fir_result_fifo_pkg.sv | 12 +
 rtl/fir_result_mem.sv | 26 ++
 rtl/fir_result_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/fir_result_fifo_pkg.sv
// Shared constants and types for the FIR accelerator result path.
// Widths here are the defaults that fir_result_fifo and its storage are built with.
package fir_result_fifo_pkg;

    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned RESULT_FIFO_DEPTH = 8;
    localparam int unsigned RESULT_FIFO_CNT_W = $clog2(RESULT_FIFO_DEPTH) + 1;

    typedef logic [DATA_WIDTH-1:0]        result_t;
    typedef logic [RESULT_FIFO_CNT_W-1:0] fifo_count_t;

endpackage

// File: rtl/fir_result_mem.sv
// DEPTH x DATA_WIDTH result storage: one synchronous write port and one combinational read port.
// Entries are not reset; the FIFO masks the read data whenever it is empty.
module fir_result_mem #(
    parameter int unsigned DATA_WIDTH = fir_result_fifo_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = fir_result_fifo_pkg::RESULT_FIFO_DEPTH,
    parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_result_fifo.sv
// Result FIFO behind the FIR core: captures one word per rising edge of result_valid_i
// and lets the CPU drain it by register pops, with occupancy, sticky flags and a threshold irq.
module fir_result_fifo #(
    parameter int unsigned DATA_WIDTH = fir_result_fifo_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = fir_result_fifo_pkg::RESULT_FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  result_valid_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic                  clr_flags_i,
    input  logic [CNT_W-1:0]      thresh_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  irq_o
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic                  valid_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, underflow_q, irq_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic is_empty, is_full, push, do_push, do_pop, ovf_set, unf_set;

    // Handshake: the core is level-based, so a push is the rising edge of result_valid_i
    // gated by enable_i; there is no back-pressure, a push into a full FIFO is dropped
    // and flagged. pop_i is a one-cycle strobe that consumes the head when non-empty.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_CNT);
    assign push     = result_valid_i & ~valid_q & enable_i;
    assign do_pop   = pop_i & ~is_empty & ~flush_i;
    assign do_push  = push & (~is_full | do_pop) & ~flush_i;
    assign ovf_set  = push & is_full & ~do_pop & ~flush_i;
    assign unf_set  = pop_i & is_empty & ~flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            valid_q <= result_valid_i;
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A set event in the same cycle as clr_flags_i wins.
            overflow_q  <= ovf_set | (overflow_q  & ~clr_flags_i);
            underflow_q <= unf_set | (underflow_q & ~clr_flags_i);
            irq_q       <= (thresh_i != '0) && (count_d >= thresh_i);
        end
    end

    fir_result_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (result_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign rdata_o     = is_empty ? '0 : mem_rdata;
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign irq_o       = irq_q;

endmodule
